// File: rtl/fibonacci_scheduler_if.sv
// Request/response bundle between two Fibonacci requesters, one consumer and the scheduler.
interface fibonacci_scheduler_if #(
  parameter int W  = 16,
  parameter int IW = 5
) ();
  logic [1:0]    req_valid;
  logic [IW-1:0] req_index0;
  logic [IW-1:0] req_index1;
  logic [1:0]    req_ready;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [W-1:0]  rsp_data;
  logic          rsp_id;
  logic          busy;

  modport slave (
    input  req_valid, req_index0, req_index1, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, busy
  );

  modport master (
    output req_valid, req_index0, req_index1, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, busy
  );
endinterface

// File: rtl/fibonacci_scheduler.sv
// Round-robin scheduler that computes F(n) mod 2^W for two requesters on one shared adder.
//
// state | meaning
// IDLE  | waiting for a request, grants one per cycle
// CALC  | iterating {a,b} <= {b,a+b} until cnt reaches zero
// DONE  | result presented, held until rsp_ready
module fibonacci_scheduler #(
  parameter int W  = 16,
  parameter int IW = 5
) (
  input logic                 clk,
  input logic                 rst,
  fibonacci_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  rsp_data_q, rsp_data_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic          id_q, id_d;
  logic          prio_q, prio_d;
  logic [1:0]    grant;
  logic          win;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      rsp_data_q <= '0;
      cnt_q      <= '0;
      id_q       <= 1'b0;
      prio_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rsp_data_q <= rsp_data_d;
      cnt_q      <= cnt_d;
      id_q       <= id_d;
      prio_q     <= prio_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    rsp_data_d = rsp_data_q;
    cnt_d      = cnt_q;
    id_d       = id_q;
    prio_d     = prio_q;
    grant      = 2'b00;
    win        = prio_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid != 2'b00) begin
          // the pointer only matters on contention; a sole requester always wins
          win    = (bus.req_valid == 2'b11) ? prio_q : bus.req_valid[1];
          grant  = win ? 2'b10 : 2'b01;
          id_d   = win;
          cnt_d  = win ? bus.req_index1 : bus.req_index0;
          a_d    = '0;
          b_d    = W'(1);
          prio_d = ~win;
          state_d = CALC;
        end
      end
      CALC: begin
        if (cnt_q != '0) begin
          a_d   = b_q;
          b_d   = a_q + b_q;
          cnt_d = cnt_q - IW'(1);
        end else begin
          rsp_data_d = a_q;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // grant is gated so nothing looks accepted while reset holds the FSM
  assign bus.req_ready = rst ? 2'b00 : grant;
  assign bus.rsp_valid = (state_q == DONE);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = id_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fibonacci_scheduler.sv
// Directed and randomized checks of fibonacci_scheduler against hand-computed values and an F(n) model.
module tb_fibonacci_scheduler;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  fibonacci_scheduler_if #(.W(16), .IW(5)) bus ();

  fibonacci_scheduler #(.W(16), .IW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] fib(input int n);
    logic [15:0] a, b, t;
    a = 16'd0;
    b = 16'd1;
    for (int k = 0; k < n; k++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic do_reset();
    rst           = 1'b1;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Inputs must be set after a rising edge; acceptance then happens on the next one.
  task automatic serve(input string tag, input logic [1:0] exp_grant, input logic exp_id,
                       input logic [15:0] exp_data, input int exp_lat, input int stall);
    int edges;
    @(negedge clk);
    check({tag, "_grant"}, bus.req_ready, exp_grant);
    bus.rsp_ready = (stall == 0);
    @(posedge clk);
    #1;
    check({tag, "_busy"}, bus.busy, 1);
    check({tag, "_ready_calc"}, bus.req_ready, 2'b00);
    bus.req_valid[exp_id] = 1'b0;
    if (exp_id) bus.req_index1 = ~bus.req_index1;
    else        bus.req_index0 = ~bus.req_index0;
    edges = 0;
    while (!bus.rsp_valid && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
    if (!bus.rsp_valid) begin
      check({tag, "_timeout"}, 0, 1);
      return;
    end
    check({tag, "_latency"}, edges, exp_lat);
    check({tag, "_data"}, bus.rsp_data, exp_data);
    check({tag, "_id"}, bus.rsp_id, exp_id);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({tag, "_stall_valid"}, bus.rsp_valid, 1);
      check({tag, "_stall_data"}, bus.rsp_data, exp_data);
      check({tag, "_stall_id"}, bus.rsp_id, exp_id);
      check({tag, "_stall_ready"}, bus.req_ready, 2'b00);
    end
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    check({tag, "_hs_ready"}, bus.req_ready, 2'b00);
    check({tag, "_hs_valid"}, bus.rsp_valid, 1);
    @(posedge clk);
    #1;
    check({tag, "_after_hs"}, bus.rsp_valid, 0);
  endtask

  initial begin : main
    int          ghost;
    int          accepted;
    int          cyc;
    bit          pend;
    logic        mprio;
    logic        win;
    logic        exp_i;
    logic [15:0] exp_d;
    logic [1:0]  g;

    rst            = 1'b1;
    bus.req_valid  = 2'b11;
    bus.req_index0 = 5'd3;
    bus.req_index1 = 5'd4;
    bus.rsp_ready  = 1'b1;
    #2;
    check("rst_ready", bus.req_ready, 2'b00);
    check("rst_valid", bus.rsp_valid, 0);
    check("rst_data", bus.rsp_data, 0);
    check("rst_id", bus.rsp_id, 0);
    check("rst_busy", bus.busy, 0);
    do_reset();

    bus.req_index0 = 5'd10;
    bus.req_valid  = 2'b01;
    serve("n10", 2'b01, 1'b0, 16'd55, 11, 0);

    do_reset();
    bus.req_index0 = 5'd1;
    bus.req_index1 = 5'd24;
    bus.req_valid  = 2'b11;
    serve("both_a0", 2'b01, 1'b0, 16'd1, 2, 0);
    serve("both_a1", 2'b10, 1'b1, 16'd46368, 25, 0);
    bus.req_index0 = 5'd1;
    bus.req_index1 = 5'd24;
    bus.req_valid  = 2'b11;
    serve("both_b0", 2'b01, 1'b0, 16'd1, 2, 0);
    serve("both_b1", 2'b10, 1'b1, 16'd46368, 25, 0);

    bus.req_index1 = 5'd25;
    bus.req_valid  = 2'b10;
    serve("n25", 2'b10, 1'b1, 16'd9489, 26, 0);
    bus.req_index1 = 5'd31;
    bus.req_valid  = 2'b10;
    serve("n31", 2'b10, 1'b1, 16'd35549, 32, 0);
    bus.req_index0 = 5'd0;
    bus.req_valid  = 2'b01;
    serve("n0", 2'b01, 1'b0, 16'd0, 1, 0);

    // pointer now favours requester 1
    bus.req_index0 = 5'd7;
    bus.req_index1 = 5'd3;
    bus.req_valid  = 2'b11;
    serve("stall", 2'b10, 1'b1, 16'd2, 4, 20);
    serve("after_stall", 2'b01, 1'b0, 16'd13, 8, 0);

    bus.req_index0 = 5'd20;
    bus.req_valid  = 2'b01;
    @(negedge clk);
    check("mid_grant", bus.req_ready, 2'b01);
    @(posedge clk);
    #1;
    bus.req_valid = 2'b00;
    repeat (5) @(posedge clk);
    #3;
    rst           = 1'b1;
    bus.req_valid = 2'b11;
    #1;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_valid", bus.rsp_valid, 0);
    check("mid_rst_data", bus.rsp_data, 0);
    check("mid_rst_id", bus.rsp_id, 0);
    check("mid_rst_ready", bus.req_ready, 2'b00);
    @(negedge clk);
    rst           = 1'b0;
    bus.req_valid = 2'b00;
    ghost = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.rsp_valid) ghost++;
    end
    check("no_ghost", ghost, 0);
    @(posedge clk);
    #1;
    bus.req_index0 = 5'd5;
    bus.req_valid  = 2'b01;
    serve("post_rst", 2'b01, 1'b0, 16'd5, 6, 0);

    do_reset();
    mprio    = 1'b0;
    pend     = 1'b0;
    accepted = 0;
    cyc      = 0;
    exp_i    = 1'b0;
    exp_d    = 16'd0;
    bus.req_index0 = 5'($urandom_range(0, 31));
    bus.req_index1 = 5'($urandom_range(0, 31));
    bus.req_valid  = 2'b11;
    while ((accepted < 1000 || pend) && cyc < 80000) begin
      @(negedge clk);
      cyc++;
      if (bus.rsp_valid && bus.rsp_ready) begin
        check("rnd_pend", pend, 1);
        check("rnd_data", bus.rsp_data, exp_d);
        check("rnd_id", bus.rsp_id, exp_i);
        pend = 1'b0;
      end
      g = bus.req_ready;
      if (g != 2'b00) begin
        check("rnd_grant_busy", pend, 0);
        win = (bus.req_valid == 2'b11) ? mprio : bus.req_valid[1];
        check("rnd_winner", g, win ? 2'b10 : 2'b01);
        exp_i = win;
        exp_d = fib(win ? int'(bus.req_index1) : int'(bus.req_index0));
        pend  = 1'b1;
        mprio = ~win;
        accepted++;
      end
      @(posedge clk);
      #1;
      if (g[0]) begin
        bus.req_index0   = 5'($urandom_range(0, 31));
        bus.req_valid[0] = (accepted < 1000) && ($urandom_range(0, 7) != 0);
      end else if (!bus.req_valid[0]) begin
        bus.req_valid[0] = (accepted < 1000) && ($urandom_range(0, 3) == 0);
      end
      if (g[1]) begin
        bus.req_index1   = 5'($urandom_range(0, 31));
        bus.req_valid[1] = (accepted < 1000) && ($urandom_range(0, 7) != 0);
      end else if (!bus.req_valid[1]) begin
        bus.req_valid[1] = (accepted < 1000) && ($urandom_range(0, 3) == 0);
      end
      if (accepted >= 1000) bus.req_valid = 2'b00;
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
    end
    check("rnd_complete", (accepted >= 1000) && !pend, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fibonacci_scheduler.md
FIBONACCI_SCHEDULER -- requirements
Module: fibonacci_scheduler

Interface
REQ-001 Parameter W, default 16, result width in bits.
REQ-002 Parameter IW, default 5, index width in bits (n = 0..2^IW-1).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  2  bit i = requester i presents a request.
REQ-006 req_index0  input  IW  index n for requester 0.
REQ-007 req_index1  input  IW  index n for requester 1.
REQ-008 req_ready  output  2  bit i = request i accepted this cycle (combinational, one-hot or zero).
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer accepts result.
REQ-011 rsp_data  output  W  F(n) modulo 2^W.
REQ-012 rsp_id  output  1  requester that issued the answered request.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 The block SHALL time-share one W-bit adder between two requesters; F(0)=0, F(1)=F(2)=1, F(k)=F(k-1)+F(k-2), additions wrap modulo 2^W.
REQ-015 FSM states SHALL be IDLE, CALC, DONE; no other reachable states.
REQ-016 IDLE: if any req_valid, the block SHALL grant exactly one requester, assert its req_ready bit, and on that edge latch index, id, a=0, b=1, cnt=index, move to CALC.
REQ-017 Arbitration SHALL be round-robin: a priority pointer selects the winner when both request; after each grant the pointer points to the other requester; a sole requester always wins.
REQ-018 req_ready SHALL be zero outside IDLE; requesters hold req_valid and index stable until ready (not checked).
REQ-019 CALC: if cnt != 0, on the edge {a,b} <= {b, a+b} and cnt <= cnt-1; if cnt == 0, rsp_data <= a and state <= DONE.
REQ-020 Latency: rsp_valid SHALL first be high in the cycle after edge n+1 counted from the acceptance edge (edge 0).
REQ-021 DONE: rsp_valid=1, rsp_data and rsp_id held stable until rsp_ready; on the edge with rsp_valid&&rsp_ready state SHALL return to IDLE.
REQ-022 No new request SHALL be accepted in the handshake cycle; earliest next acceptance is the following cycle.
REQ-023 Back-pressure: rsp_ready low SHALL stall indefinitely in DONE with outputs unchanged.
REQ-024 Index 0 SHALL produce rsp_data=0 with latency 1 (CALC for one cycle).
REQ-025 Index changes on a requester after acceptance SHALL not affect the in-flight computation.

Reset
REQ-026 rst high SHALL immediately (no clock) force state=IDLE, rsp_valid=0, rsp_data=0, rsp_id=0, busy=0, a=0, b=0, cnt=0, priority pointer=requester 0.
REQ-027 Reset mid-CALC or mid-DONE SHALL discard the in-flight request; no response is ever produced for it.
REQ-028 While rst is high req_ready SHALL be 0.

Verification
REQ-029 Requester 0 alone, n=10 -> req_ready=01 one cycle, rsp_valid 11 edges later, rsp_data=55, rsp_id=0.
REQ-030 Both request simultaneously after reset, n0=1, n1=24, rsp_ready=1 -> first response id 0 data 1, second id 1 data 46368; repeat both -> id 0 served first again.
REQ-031 Wrap: n=25 -> 9489; n=31 -> 35549; n=0 -> 0 with 1-cycle CALC.
REQ-032 rsp_ready held low 20 cycles in DONE -> rsp_valid, rsp_data, rsp_id stable; req_ready stays 00 despite pending requests.
REQ-033 rst asserted asynchronously mid-CALC (n=20) -> outputs cleared before next edge; after release no response for n=20; new request n=5 -> 5.
REQ-034 Random 1000-request run against F(n) mod 2^16 model -> every response matches, ids alternate whenever both requesters stay valid.
